// File: rtl/ifq_fetch_ctrl_pkg.sv
// ifq_pkg: shared FSM state type, line geometry and line-alignment helper for the fetch controller.
//   state_t    : IDLE / REQ / WAIT / DRAIN
//   LINE_BYTES : fetch line size in bytes (128-bit line)
//   LINE_MASK  : clears the byte-offset bits of an address
package ifq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;

    localparam int LINE_BYTES = 16;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/ifq_fetch_ctrl_timeout_cnt.sv
// fetch_timeout_cnt: counts cycles spent waiting for a memory response and flags expiry.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count from zero (entry into a waiting state)
//   en       : count this cycle (controller is waiting)
//   expired  : high during the MAX-th waiting cycle
module fetch_timeout_cnt #(
    parameter int MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count;

    // Saturates at LAST so a stuck enable never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = en && count == LAST;

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// ifq_fetch_ctrl: fetches 16-byte instruction lines from memory into the fetch queue,
// one request outstanding, with redirect flush and response timeout.
//   i_clk, i_rst                         : clock, synchronous active-high reset
//   i_fetch_addr, i_queue_ready          : next line address, queue has room
//   i_redirect_valid, i_redirect_addr    : taken jump/branch pulse and target
//   o_mem_req, o_mem_addr, i_mem_gnt     : line request handshake (aligned address)
//   i_mem_rvalid, i_mem_rdata            : memory response
//   o_dout, o_dout_valid                 : line written into the queue
//   o_flush, o_pc_load, o_pc_load_addr   : queue flush and PC reload pulses
//   o_busy, o_err                        : not idle, sticky timeout error
module ifq_fetch_ctrl
    import ifq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int LINE_BYTES     = ifq_pkg::LINE_BYTES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [31:0]  i_fetch_addr,
    input  logic         i_queue_ready,
    input  logic         i_redirect_valid,
    input  logic [31:0]  i_redirect_addr,
    output logic         o_mem_req,
    output logic [31:0]  o_mem_addr,
    input  logic         i_mem_gnt,
    input  logic         i_mem_rvalid,
    input  logic [127:0] i_mem_rdata,
    output logic [127:0] o_dout,
    output logic         o_dout_valid,
    output logic         o_flush,
    output logic         o_pc_load,
    output logic [31:0]  o_pc_load_addr,
    output logic         o_busy,
    output logic         o_err
);

    if (LINE_BYTES != ifq_pkg::LINE_BYTES) begin : g_bad_line
        $error("ifq_fetch_ctrl supports only 16-byte lines");
    end

    state_t state;
    logic   stale;
    logic   clr;
    logic   en;
    logic   expired;

    // The count restarts whenever a waiting state is entered, including WAIT -> DRAIN.
    assign clr = (state == ST_REQ && i_mem_gnt) || (state == ST_WAIT && i_redirect_valid);
    assign en  = state == ST_WAIT || state == ST_DRAIN;

    fetch_timeout_cnt #(.MAX(TIMEOUT_CYCLES)) u_timeout (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (clr),
        .en      (en),
        .expired (expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            stale          <= 1'b0;
            o_mem_req      <= 1'b0;
            o_mem_addr     <= '0;
            o_dout         <= '0;
            o_dout_valid   <= 1'b0;
            o_flush        <= 1'b0;
            o_pc_load      <= 1'b0;
            o_pc_load_addr <= '0;
            o_busy         <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_dout_valid <= 1'b0;
            o_flush      <= i_redirect_valid;
            o_pc_load    <= i_redirect_valid;
            if (i_redirect_valid)
                o_pc_load_addr <= i_redirect_addr;
            case (state)
                ST_IDLE: begin
                    if (i_queue_ready && !i_redirect_valid) begin
                        o_mem_addr <= line_align(i_fetch_addr);
                        o_mem_req  <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                // The request is never withdrawn; a redirect only marks it stale.
                ST_REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        stale     <= 1'b0;
                        state     <= (stale || i_redirect_valid) ? ST_DRAIN : ST_WAIT;
                    end else if (i_redirect_valid) begin
                        stale <= 1'b1;
                    end
                end
                // A response that coincides with a redirect belongs to the old path.
                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        o_dout_valid <= !i_redirect_valid;
                        if (!i_redirect_valid)
                            o_dout <= i_mem_rdata;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (expired) begin
                        o_err   <= 1'b1;
                        o_flush <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (i_redirect_valid) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_mem_rvalid) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (expired) begin
                        o_err   <= 1'b1;
                        o_flush <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// tb_ifq_fetch_ctrl: directed self-checking bench for ifq_fetch_ctrl.
module tb_ifq_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  fetch_addr;
    logic         queue_ready;
    logic         redirect_valid;
    logic [31:0]  redirect_addr;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
    logic [127:0] dout;
    logic         dout_valid;
    logic         flush;
    logic         pc_load;
    logic [31:0]  pc_load_addr;
    logic         busy;
    logic         err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifq_fetch_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_fetch_addr     (fetch_addr),
        .i_queue_ready    (queue_ready),
        .i_redirect_valid (redirect_valid),
        .i_redirect_addr  (redirect_addr),
        .o_mem_req        (mem_req),
        .o_mem_addr       (mem_addr),
        .i_mem_gnt        (mem_gnt),
        .i_mem_rvalid     (mem_rvalid),
        .i_mem_rdata      (mem_rdata),
        .o_dout           (dout),
        .o_dout_valid     (dout_valid),
        .o_flush          (flush),
        .o_pc_load        (pc_load),
        .o_pc_load_addr   (pc_load_addr),
        .o_busy           (busy),
        .o_err            (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".mem_req"}, 128'(mem_req), 128'd0);
        chk({tag, ".mem_addr"}, 128'(mem_addr), 128'd0);
        chk({tag, ".dout"}, dout, 128'd0);
        chk({tag, ".dout_valid"}, 128'(dout_valid), 128'd0);
        chk({tag, ".flush"}, 128'(flush), 128'd0);
        chk({tag, ".pc_load"}, 128'(pc_load), 128'd0);
        chk({tag, ".pc_load_addr"}, 128'(pc_load_addr), 128'd0);
        chk({tag, ".busy"}, 128'(busy), 128'd0);
        chk({tag, ".err"}, 128'(err), 128'd0);
    endtask

    // Issue a fetch from IDLE and have it granted immediately; leaves the DUT in WAIT.
    task automatic fetch_granted(input logic [31:0] addr);
        fetch_addr  = addr;
        queue_ready = 1'b1;
        step();
        queue_ready = 1'b0;
        mem_gnt     = 1'b1;
        step();
        mem_gnt     = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        fetch_addr     = '0;
        queue_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Queue full: stay idle, no request.
        step();
        step();
        step();
        chk("noready.mem_req", 128'(mem_req), 128'd0);
        chk("noready.busy", 128'(busy), 128'd0);

        // Basic fetch: unaligned address, grant at once, response two cycles after grant.
        fetch_addr  = 32'h0000_0014;
        queue_ready = 1'b1;
        step();
        chk("basic.mem_req", 128'(mem_req), 128'd1);
        chk("basic.mem_addr", 128'(mem_addr), 128'h10);
        chk("basic.busy", 128'(busy), 128'd1);
        queue_ready = 1'b0;
        mem_gnt     = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("basic.wait_req", 128'(mem_req), 128'd0);
        chk("basic.wait_busy", 128'(busy), 128'd1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = {32{4'hA}};
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        chk("basic.dout_valid", 128'(dout_valid), 128'd1);
        chk("basic.dout", dout, {32{4'hA}});
        chk("basic.flush", 128'(flush), 128'd0);
        chk("basic.idle", 128'(busy), 128'd0);
        step();
        chk("basic.dout_valid_drop", 128'(dout_valid), 128'd0);

        // Grant held off for five cycles: request and address stay put.
        fetch_addr  = 32'h1234_5678;
        queue_ready = 1'b1;
        step();
        queue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d.mem_req", i), 128'(mem_req), 128'd1);
            chk($sformatf("stall%0d.mem_addr", i), 128'(mem_addr), 128'h1234_5670);
            step();
        end
        chk("stall.still_req", 128'(mem_req), 128'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("stall.granted", 128'(mem_req), 128'd0);
        chk("stall.busy", 128'(busy), 128'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = {32{4'h5}};
        step();
        mem_rvalid = 1'b0;
        chk("stall.dout_valid", 128'(dout_valid), 128'd1);
        chk("stall.dout", dout, {32{4'h5}});

        // Redirect while waiting, response arrives later and is dropped.
        step();
        fetch_granted(32'h0000_0100);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("redir.flush", 128'(flush), 128'd1);
        chk("redir.pc_load", 128'(pc_load), 128'd1);
        chk("redir.pc_load_addr", 128'(pc_load_addr), 128'h200);
        chk("redir.busy", 128'(busy), 128'd1);
        step();
        chk("redir.flush_drop", 128'(flush), 128'd0);
        chk("redir.pc_load_drop", 128'(pc_load), 128'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = {32{4'h3}};
        step();
        mem_rvalid = 1'b0;
        chk("redir.no_dout", 128'(dout_valid), 128'd0);
        chk("redir.idle", 128'(busy), 128'd0);
        chk("redir.dout_kept", dout, {32{4'h5}});

        // Redirect in the same cycle as the response.
        fetch_granted(32'h0000_0120);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0300;
        mem_rvalid     = 1'b1;
        mem_rdata      = {32{4'h7}};
        step();
        redirect_valid = 1'b0;
        mem_rvalid     = 1'b0;
        chk("same.flush", 128'(flush), 128'd1);
        chk("same.dout_valid", 128'(dout_valid), 128'd0);
        chk("same.pc_load_addr", 128'(pc_load_addr), 128'h300);
        chk("same.idle", 128'(busy), 128'd0);
        step();
        chk("same.flush_drop", 128'(flush), 128'd0);

        // Redirect while the request is still ungranted: handshake completes, then drain.
        fetch_addr  = 32'h0000_0140;
        queue_ready = 1'b1;
        step();
        queue_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0400;
        step();
        redirect_valid = 1'b0;
        chk("reqredir.flush", 128'(flush), 128'd1);
        chk("reqredir.mem_req_held", 128'(mem_req), 128'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("reqredir.granted", 128'(mem_req), 128'd0);
        chk("reqredir.busy", 128'(busy), 128'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = {32{4'h9}};
        step();
        mem_rvalid = 1'b0;
        chk("reqredir.no_dout", 128'(dout_valid), 128'd0);
        chk("reqredir.idle", 128'(busy), 128'd0);

        // Timeout: 64 waiting cycles with no response.
        fetch_granted(32'h0000_0500);
        for (int i = 0; i < 63; i++)
            step();
        chk("tmo.not_yet_err", 128'(err), 128'd0);
        chk("tmo.not_yet_busy", 128'(busy), 128'd1);
        step();
        chk("tmo.err", 128'(err), 128'd1);
        chk("tmo.flush", 128'(flush), 128'd1);
        chk("tmo.dout_valid", 128'(dout_valid), 128'd0);
        chk("tmo.idle", 128'(busy), 128'd0);
        step();
        chk("tmo.flush_drop", 128'(flush), 128'd0);
        chk("tmo.err_sticky", 128'(err), 128'd1);

        // Normal fetch after the timeout.
        fetch_granted(32'h0000_060C);
        mem_rvalid = 1'b1;
        mem_rdata  = {32{4'hC}};
        step();
        mem_rvalid = 1'b0;
        chk("post.dout_valid", 128'(dout_valid), 128'd1);
        chk("post.dout", dout, {32{4'hC}});
        chk("post.err_sticky", 128'(err), 128'd1);
        chk("post.mem_addr", 128'(mem_addr), 128'h600);

        // Reset in WAIT, then a stray response.
        fetch_granted(32'h0000_0700);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        mem_rvalid = 1'b1;
        mem_rdata  = {32{4'hF}};
        step();
        mem_rvalid = 1'b0;
        chk_reset_outputs("stray");
        step();
        chk("stray.later_dout_valid", 128'(dout_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
